// File: rtl/pe_os.sv
// Output-stationary MAC processing element: forwards row/column operands,
// accumulates tagged row x column products and shifts finished results down a drain chain.
module pe_os #(
  parameter int BITWIDTH = 8,
  parameter int ACCWIDTH = 2 * BITWIDTH + 8,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [BITWIDTH-1:0] iRow,
  input  logic                iRowValid,
  input  logic                iRowFirst,
  input  logic                iRowLast,
  input  logic [BITWIDTH-1:0] iCol,
  input  logic                iColValid,
  output logic [BITWIDTH-1:0] oRow,
  output logic                oRowValid,
  output logic                oRowFirst,
  output logic                oRowLast,
  output logic [BITWIDTH-1:0] oCol,
  output logic                oColValid,
  input  logic [ACCWIDTH-1:0] iDrain,
  input  logic                iDrainValid,
  output logic [ACCWIDTH-1:0] oDrain,
  output logic                oDrainValid,
  output logic [ACCWIDTH-1:0] oAcc,
  output logic                oSat,
  output logic                oOverrun
);

  localparam int  PW  = 2 * BITWIDTH;
  localparam logic SGN = (SIGNED != 0);
  localparam logic SAT = (SATURATE != 0);
  localparam logic [ACCWIDTH-1:0] SMAX = {1'b0, {(ACCWIDTH - 1){1'b1}}};
  localparam logic [ACCWIDTH-1:0] SMIN = {1'b1, {(ACCWIDTH - 1){1'b0}}};
  localparam logic [ACCWIDTH-1:0] UMAX = {ACCWIDTH{1'b1}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t              state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic                sat_q, sat_d;
  logic [ACCWIDTH-1:0] drain_q, drain_d;
  logic                drain_valid_q, drain_valid_d;
  logic                overrun_q, overrun_d;
  logic [BITWIDTH-1:0] row_q, col_q;
  logic                row_valid_q, row_first_q, row_last_q, col_valid_q;

  logic [PW-1:0]       row_x, col_x;
  logic [2*PW-1:0]     prod_full;
  logic [PW-1:0]       prod_raw;
  logic [ACCWIDTH-1:0] prod_ext;
  logic [ACCWIDTH-1:0] base;
  logic [ACCWIDTH:0]   sum_x;
  logic                beat, start, overflow;
  logic [ACCWIDTH-1:0] result;

  // Low PW bits of the product of PW-bit extended operands equal the exact
  // signed/unsigned product, so one unsigned multiplier serves both modes.
  assign row_x     = {{BITWIDTH{SGN & iRow[BITWIDTH-1]}}, iRow};
  assign col_x     = {{BITWIDTH{SGN & iCol[BITWIDTH-1]}}, iCol};
  assign prod_full = row_x * col_x;
  assign prod_raw  = prod_full[PW-1:0];

  generate
    if (ACCWIDTH > PW) begin : g_ext
      assign prod_ext = {{(ACCWIDTH - PW){SGN & prod_raw[PW-1]}}, prod_raw};
    end else begin : g_noext
      assign prod_ext = prod_raw;
    end
  endgenerate

  assign beat  = iRowValid & iColValid;
  assign start = (state_q == IDLE) | iRowFirst;
  assign base  = start ? '0 : acc_q;
  assign sum_x = {SGN & base[ACCWIDTH-1], base} + {SGN & prod_ext[ACCWIDTH-1], prod_ext};

  always_comb begin
    overflow = 1'b0;
    result   = sum_x[ACCWIDTH-1:0];
    if (SGN) begin
      overflow = sum_x[ACCWIDTH] ^ sum_x[ACCWIDTH-1];
      if (overflow && SAT) result = sum_x[ACCWIDTH] ? SMIN : SMAX;
    end else begin
      overflow = sum_x[ACCWIDTH];
      if (overflow && SAT) result = UMAX;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    drain_d       = iDrain;
    drain_valid_d = iDrainValid;
    overrun_d     = overrun_q;
    if (beat) begin
      acc_d   = result;
      sat_d   = start ? overflow : (sat_q | overflow);
      state_d = iRowLast ? IDLE : ACC;
      // A local result always takes the drain slot; a colliding upstream word is lost.
      if (iRowLast) begin
        drain_d       = result;
        drain_valid_d = 1'b1;
        if (iDrainValid) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      drain_q       <= '0;
      drain_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      row_q         <= '0;
      row_valid_q   <= 1'b0;
      row_first_q   <= 1'b0;
      row_last_q    <= 1'b0;
      col_q         <= '0;
      col_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      drain_q       <= drain_d;
      drain_valid_q <= drain_valid_d;
      overrun_q     <= overrun_d;
      row_q         <= iRow;
      row_valid_q   <= iRowValid;
      row_first_q   <= iRowFirst;
      row_last_q    <= iRowLast;
      col_q         <= iCol;
      col_valid_q   <= iColValid;
    end
  end

  assign oRow        = row_q;
  assign oRowValid   = row_valid_q;
  assign oRowFirst   = row_first_q;
  assign oRowLast    = row_last_q;
  assign oCol        = col_q;
  assign oColValid   = col_valid_q;
  assign oDrain      = drain_q;
  assign oDrainValid = drain_valid_q;
  assign oAcc        = acc_q;
  assign oSat        = sat_q;
  assign oOverrun    = overrun_q;

endmodule

// File: tb/tb_pe_os.sv
// Directed bench for pe_os: a signed 8/24 saturating PE plus unsigned 8/16
// saturating and wrapping PEs, all fed from the same stimulus.
module tb_pe_os;

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  iRow, iCol;
  logic        iRowValid, iRowFirst, iRowLast, iColValid;
  logic [23:0] iDrain;
  logic        iDrainValid;
  logic [15:0] iDrain16;

  logic [7:0]  s_oRow, s_oCol, us_oRow, us_oCol, uw_oRow, uw_oCol;
  logic        s_oRowValid, s_oRowFirst, s_oRowLast, s_oColValid;
  logic        us_oRowValid, us_oRowFirst, us_oRowLast, us_oColValid;
  logic        uw_oRowValid, uw_oRowFirst, uw_oRowLast, uw_oColValid;
  logic [23:0] s_oDrain, s_oAcc;
  logic [15:0] us_oDrain, us_oAcc, uw_oDrain, uw_oAcc;
  logic        s_oDrainValid, s_oSat, s_oOverrun;
  logic        us_oDrainValid, us_oSat, us_oOverrun;
  logic        uw_oDrainValid, uw_oSat, uw_oOverrun;

  int n_checks = 0;
  int n_fail   = 0;

  assign iDrain16 = iDrain[15:0];

  always #5 clk = ~clk;

  pe_os #(.BITWIDTH(8), .ACCWIDTH(24), .SIGNED(1), .SATURATE(1)) dut_s (
    .clk(clk), .resetN(resetN),
    .iRow(iRow), .iRowValid(iRowValid), .iRowFirst(iRowFirst), .iRowLast(iRowLast),
    .iCol(iCol), .iColValid(iColValid),
    .oRow(s_oRow), .oRowValid(s_oRowValid), .oRowFirst(s_oRowFirst), .oRowLast(s_oRowLast),
    .oCol(s_oCol), .oColValid(s_oColValid),
    .iDrain(iDrain), .iDrainValid(iDrainValid),
    .oDrain(s_oDrain), .oDrainValid(s_oDrainValid),
    .oAcc(s_oAcc), .oSat(s_oSat), .oOverrun(s_oOverrun)
  );

  pe_os #(.BITWIDTH(8), .ACCWIDTH(16), .SIGNED(0), .SATURATE(1)) dut_us (
    .clk(clk), .resetN(resetN),
    .iRow(iRow), .iRowValid(iRowValid), .iRowFirst(iRowFirst), .iRowLast(iRowLast),
    .iCol(iCol), .iColValid(iColValid),
    .oRow(us_oRow), .oRowValid(us_oRowValid), .oRowFirst(us_oRowFirst), .oRowLast(us_oRowLast),
    .oCol(us_oCol), .oColValid(us_oColValid),
    .iDrain(iDrain16), .iDrainValid(iDrainValid),
    .oDrain(us_oDrain), .oDrainValid(us_oDrainValid),
    .oAcc(us_oAcc), .oSat(us_oSat), .oOverrun(us_oOverrun)
  );

  pe_os #(.BITWIDTH(8), .ACCWIDTH(16), .SIGNED(0), .SATURATE(0)) dut_uw (
    .clk(clk), .resetN(resetN),
    .iRow(iRow), .iRowValid(iRowValid), .iRowFirst(iRowFirst), .iRowLast(iRowLast),
    .iCol(iCol), .iColValid(iColValid),
    .oRow(uw_oRow), .oRowValid(uw_oRowValid), .oRowFirst(uw_oRowFirst), .oRowLast(uw_oRowLast),
    .oCol(uw_oCol), .oColValid(uw_oColValid),
    .iDrain(iDrain16), .iDrainValid(iDrainValid),
    .oDrain(uw_oDrain), .oDrainValid(uw_oDrainValid),
    .oAcc(uw_oAcc), .oSat(uw_oSat), .oOverrun(uw_oOverrun)
  );

  task automatic set_in(input logic [7:0] row, input logic [7:0] col, input logic rv,
                        input logic cv, input logic first, input logic last,
                        input logic dv, input logic [23:0] d);
    iRow = row; iCol = col; iRowValid = rv; iColValid = cv;
    iRowFirst = first; iRowLast = last; iDrainValid = dv; iDrain = d;
    $display("[%0t] drive row=%h col=%h rv=%0d cv=%0d first=%0d last=%0d dv=%0d drain=%h",
             $time, row, col, rv, cv, first, last, dv, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (s_oAcc !== 24'h0) begin n_fail++; $display("FAIL reset_acc got %h exp %h", s_oAcc, 24'h0); end
    n_checks++; if (s_oDrain !== 24'h0) begin n_fail++; $display("FAIL reset_drain got %h exp %h", s_oDrain, 24'h0); end
    n_checks++; if (s_oRow !== 8'h0) begin n_fail++; $display("FAIL reset_row got %h exp %h", s_oRow, 8'h0); end
    n_checks++; if ({s_oDrainValid, s_oSat, s_oOverrun, s_oRowValid} !== 4'b0)
      begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {s_oDrainValid, s_oSat, s_oOverrun, s_oRowValid}); end
  endtask

  task automatic test_signed_acc();
    set_in(8'd3, 8'd4, 1, 1, 1, 0, 0, 24'h0); tick();
    n_checks++; if (s_oAcc !== 24'h00000C) begin n_fail++; $display("FAIL sacc_b1 got %h exp %h", s_oAcc, 24'h00000C); end
    set_in(8'hFE, 8'd7, 1, 1, 0, 0, 0, 24'h0); tick();
    n_checks++; if (s_oAcc !== 24'hFFFFFE) begin n_fail++; $display("FAIL sacc_b2 got %h exp %h", s_oAcc, 24'hFFFFFE); end
    n_checks++; if (s_oDrainValid !== 1'b0) begin n_fail++; $display("FAIL sacc_early_valid got %b exp 0", s_oDrainValid); end
    set_in(8'd5, 8'hFF, 1, 1, 0, 1, 0, 24'h0); tick();
    n_checks++; if (s_oDrain !== 24'hFFFFF9) begin n_fail++; $display("FAIL sacc_drain got %h exp %h", s_oDrain, 24'hFFFFF9); end
    n_checks++; if (s_oDrainValid !== 1'b1) begin n_fail++; $display("FAIL sacc_valid got %b exp 1", s_oDrainValid); end
    n_checks++; if (s_oSat !== 1'b0) begin n_fail++; $display("FAIL sacc_sat got %b exp 0", s_oSat); end
  endtask

  task automatic test_one_sided();
    set_in(8'hA5, 8'h11, 1, 0, 0, 0, 0, 24'h0); tick();
    n_checks++; if (s_oRow !== 8'hA5) begin n_fail++; $display("FAIL pass_row got %h exp %h", s_oRow, 8'hA5); end
    n_checks++; if ({s_oRowValid, s_oColValid} !== 2'b10) begin n_fail++; $display("FAIL pass_valids got %b exp 10", {s_oRowValid, s_oColValid}); end
    n_checks++; if (s_oAcc !== 24'hFFFFF9) begin n_fail++; $display("FAIL pass_acc_hold got %h exp %h", s_oAcc, 24'hFFFFF9); end
    n_checks++; if (s_oDrainValid !== 1'b0) begin n_fail++; $display("FAIL pass_pulse got %b exp 0", s_oDrainValid); end
    set_in(8'h22, 8'h3C, 0, 1, 0, 1, 0, 24'h0); tick();
    n_checks++; if ({s_oCol, s_oRowLast} !== 9'h079) begin n_fail++; $display("FAIL pass_col got %h exp %h", {s_oCol, s_oRowLast}, 9'h079); end
    n_checks++; if (s_oAcc !== 24'hFFFFF9) begin n_fail++; $display("FAIL col_only_hold got %h exp %h", s_oAcc, 24'hFFFFF9); end
  endtask

  task automatic test_unsigned_sat();
    set_in(8'hFF, 8'hFF, 1, 1, 1, 0, 0, 24'h0); tick();
    n_checks++; if (us_oAcc !== 16'hFE01) begin n_fail++; $display("FAIL usat_b1 got %h exp %h", us_oAcc, 16'hFE01); end
    n_checks++; if (us_oSat !== 1'b0) begin n_fail++; $display("FAIL usat_b1_sat got %b exp 0", us_oSat); end
    set_in(8'hFF, 8'hFF, 1, 1, 0, 1, 0, 24'h0); tick();
    n_checks++; if (us_oDrain !== 16'hFFFF) begin n_fail++; $display("FAIL usat_drain got %h exp %h", us_oDrain, 16'hFFFF); end
    n_checks++; if (us_oSat !== 1'b1) begin n_fail++; $display("FAIL usat_flag got %b exp 1", us_oSat); end
    n_checks++; if (uw_oDrain !== 16'hFC02) begin n_fail++; $display("FAIL uwrap_drain got %h exp %h", uw_oDrain, 16'hFC02); end
    n_checks++; if (uw_oSat !== 1'b1) begin n_fail++; $display("FAIL uwrap_flag got %b exp 1", uw_oSat); end
  endtask

  task automatic test_idle_restart();
    set_in(8'd2, 8'd3, 1, 1, 0, 0, 0, 24'h0); tick();
    n_checks++; if (us_oAcc !== 16'h0006) begin n_fail++; $display("FAIL restart_acc got %h exp %h", us_oAcc, 16'h0006); end
    n_checks++; if (us_oSat !== 1'b0) begin n_fail++; $display("FAIL restart_sat got %b exp 0", us_oSat); end
    n_checks++; if (uw_oAcc !== 16'h0006) begin n_fail++; $display("FAIL restart_wacc got %h exp %h", uw_oAcc, 16'h0006); end
  endtask

  task automatic test_drain_pass();
    set_in(8'h0, 8'h0, 0, 0, 0, 0, 1, 24'hABCDEF); tick();
    n_checks++; if (s_oDrain !== 24'hABCDEF) begin n_fail++; $display("FAIL chain_data got %h exp %h", s_oDrain, 24'hABCDEF); end
    n_checks++; if ({s_oDrainValid, s_oOverrun} !== 2'b10) begin n_fail++; $display("FAIL chain_flags got %b exp 10", {s_oDrainValid, s_oOverrun}); end
  endtask

  task automatic test_collision();
    set_in(8'd2, 8'd3, 1, 1, 1, 1, 1, 24'h123456); tick();
    n_checks++; if (s_oDrain !== 24'h000006) begin n_fail++; $display("FAIL coll_drain got %h exp %h", s_oDrain, 24'h000006); end
    n_checks++; if ({s_oDrainValid, s_oOverrun} !== 2'b11) begin n_fail++; $display("FAIL coll_flags got %b exp 11", {s_oDrainValid, s_oOverrun}); end
    set_in(8'h0, 8'h0, 0, 0, 0, 0, 1, 24'h000111); tick();
    n_checks++; if (s_oDrain !== 24'h000111) begin n_fail++; $display("FAIL coll_next got %h exp %h", s_oDrain, 24'h000111); end
    set_in(8'h0, 8'h0, 0, 0, 0, 0, 0, 24'h0); tick();
    n_checks++; if ({s_oDrainValid, s_oOverrun} !== 2'b01) begin n_fail++; $display("FAIL coll_sticky got %b exp 01", {s_oDrainValid, s_oOverrun}); end
  endtask

  task automatic test_async_reset();
    set_in(8'd16, 8'd16, 1, 1, 1, 0, 1, 24'h000222); tick();
    n_checks++; if ({s_oAcc, s_oDrain} !== 48'h000100_000222)
      begin n_fail++; $display("FAIL mid_state got %h exp %h", {s_oAcc, s_oDrain}, 48'h000100_000222); end
    #2 resetN = 1'b0;
    #1;
    n_checks++; if ({s_oAcc, s_oDrain} !== 48'h0) begin n_fail++; $display("FAIL areset_data got %h exp 0", {s_oAcc, s_oDrain}); end
    n_checks++; if ({s_oRow, s_oCol} !== 16'h0) begin n_fail++; $display("FAIL areset_rowcol got %h exp 0", {s_oRow, s_oCol}); end
    n_checks++; if ({s_oRowValid, s_oColValid, s_oDrainValid, s_oSat, s_oOverrun} !== 5'b0)
      begin n_fail++; $display("FAIL areset_flags got %b exp 00000", {s_oRowValid, s_oColValid, s_oDrainValid, s_oSat, s_oOverrun}); end
    resetN = 1'b1;
    set_in(8'd2, 8'd2, 1, 1, 0, 1, 0, 24'h0); tick();
    n_checks++; if ({s_oAcc, s_oDrain} !== 48'h000004_000004)
      begin n_fail++; $display("FAIL post_reset got %h exp %h", {s_oAcc, s_oDrain}, 48'h000004_000004); end
    n_checks++; if (s_oDrainValid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid got %b exp 1", s_oDrainValid); end
  endtask

  initial begin
    resetN = 1'b0;
    set_in(8'h0, 8'h0, 0, 0, 0, 0, 0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    resetN = 1'b1;
    test_signed_acc();
    test_one_sided();
    test_unsigned_sat();
    test_idle_restart();
    test_drain_pass();
    test_collision();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
